// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared SPI flash opcodes, arbiter state encoding and byte-order helper.
// Also imported by the ibus-side flash reset sequencer.
package flash_pkg;

   localparam logic [7:0] SPI_READ      = 8'h03;
   localparam logic [7:0] SPI_RESET_EN  = 8'h66;
   localparam logic [7:0] SPI_RESET_REQ = 8'h99;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   // spi_tx returns the first flash byte in [31:24]; the CPU expects it in [7:0].
   function automatic logic [31:0] byte_swap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/flash_arbiter_rr_arb2.sv
// rtl/flash_arbiter_rr_arb2.sv - two-requester picker, round-robin or fixed m1 priority.
// last: 0 = m0 was granted most recently, 1 = m1. grant is one-hot, bit 0 = m0.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       prio,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (prio || !last) ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/flash_arbiter.sv
// rtl/flash_arbiter.sv - shares one SPI flash read engine between the ibus (m0) and dbus (m1).
// Serialises reads, byte-swaps returned words, and absorbs masters that abandon a cycle.
module flash_arbiter
   import flash_pkg::*;
#(
   parameter logic [23:0] FLASH_BASE = 24'h100000,
   parameter bit          M1_PRIO    = 1'b0
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic [31:0] m0_adr,
   input  logic        m0_cyc,
   output logic        m0_ack,
   output logic [31:0] m0_rdt,
   input  logic [31:0] m1_adr,
   input  logic        m1_cyc,
   output logic        m1_ack,
   output logic [31:0] m1_rdt,
   output logic        spi_req,
   output logic [23:0] spi_addr,
   output logic [7:0]  spi_code,
   output logic        spi_tx_addr,
   output logic        spi_no_read,
   input  logic [31:0] spi_rdata,
   input  logic        spi_ready
);

   arb_state_t  state_q, state_d;
   logic        owner_q;      // 0 = m0, 1 = m1; also serves as last_grant
   logic [1:0]  pick;
   logic        take;
   logic        capture;
   logic [31:0] data_q;
   logic        spi_req_q;
   logic [23:0] spi_addr_q;
   logic        unused_bits;

   rr_arb2 u_arb (
      .req   ({m1_cyc, m0_cyc}),
      .last  (owner_q),
      .prio  (M1_PRIO),
      .grant (pick)
   );

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // spi_ready also gates the first issue after a reset that hit mid-transfer
            if (spi_ready && (m0_cyc || m1_cyc)) begin
               take    = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_BUSY;
         ST_BUSY: begin
            if (spi_ready) begin
               capture = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= 1'b1;
         data_q     <= '0;
         spi_req_q  <= 1'b0;
         spi_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         spi_req_q <= take;
         if (take) begin
            owner_q    <= pick[1];
            spi_addr_q <= (pick[1] ? m1_adr[23:0] : m0_adr[23:0]) | FLASH_BASE;
         end
         if (capture) begin
            data_q <= byte_swap32(spi_rdata);
         end
      end
   end

   // An abandoned cycle simply finds its cyc low in DONE and gets no ack.
   assign m0_ack = (state_q == ST_DONE) && !owner_q && m0_cyc;
   assign m1_ack = (state_q == ST_DONE) &&  owner_q && m1_cyc;
   assign m0_rdt = m0_ack ? data_q : 32'h0;
   assign m1_rdt = m1_ack ? data_q : 32'h0;

   assign spi_req     = spi_req_q;
   assign spi_addr    = spi_addr_q;
   assign spi_code    = SPI_READ;
   assign spi_tx_addr = 1'b1;
   assign spi_no_read = 1'b0;

   assign unused_bits = ^{m0_adr[31:24], m1_adr[31:24], pick[0]};

endmodule

// File: tb/tb_flash_arbiter.sv
// tb/tb_flash_arbiter.sv - directed bench for flash_arbiter with a behavioural spi_tx model.
// Instance 0 is round-robin, instance 1 has M1_PRIO=1.
module tb_flash_arbiter;

   typedef struct {
      bit          m;
      logic [31:0] adr;
      logic [31:0] word;
      logic [23:0] exp_addr;
      logic [31:0] exp_rdt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        model_rst = 1'b1;

   logic [31:0] m0_adr[2], m1_adr[2], m0_rdt[2], m1_rdt[2], spi_rdata[2];
   logic        m0_cyc[2], m1_cyc[2], m0_ack[2], m1_ack[2];
   logic        spi_req[2], spi_tx_addr[2], spi_no_read[2], spi_ready[2];
   logic        hold[2], mready[2];
   logic [23:0] spi_addr[2];
   logic [7:0]  spi_code[2];
   logic [6:0]  mcnt[2];
   int          reqs[2];
   logic        viol, dbl, rdtbad;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   flash_arbiter #(.FLASH_BASE(24'h100000), .M1_PRIO(1'b0)) dut0 (
      .wb_clk(clk), .wb_rst(rst),
      .m0_adr(m0_adr[0]), .m0_cyc(m0_cyc[0]), .m0_ack(m0_ack[0]), .m0_rdt(m0_rdt[0]),
      .m1_adr(m1_adr[0]), .m1_cyc(m1_cyc[0]), .m1_ack(m1_ack[0]), .m1_rdt(m1_rdt[0]),
      .spi_req(spi_req[0]), .spi_addr(spi_addr[0]), .spi_code(spi_code[0]),
      .spi_tx_addr(spi_tx_addr[0]), .spi_no_read(spi_no_read[0]),
      .spi_rdata(spi_rdata[0]), .spi_ready(spi_ready[0])
   );

   flash_arbiter #(.FLASH_BASE(24'h100000), .M1_PRIO(1'b1)) dut1 (
      .wb_clk(clk), .wb_rst(rst),
      .m0_adr(m0_adr[1]), .m0_cyc(m0_cyc[1]), .m0_ack(m0_ack[1]), .m0_rdt(m0_rdt[1]),
      .m1_adr(m1_adr[1]), .m1_cyc(m1_cyc[1]), .m1_ack(m1_ack[1]), .m1_rdt(m1_rdt[1]),
      .spi_req(spi_req[1]), .spi_addr(spi_addr[1]), .spi_code(spi_code[1]),
      .spi_tx_addr(spi_tx_addr[1]), .spi_no_read(spi_no_read[1]),
      .spi_rdata(spi_rdata[1]), .spi_ready(spi_ready[1])
   );

   assign spi_ready[0] = mready[0] & ~hold[0];
   assign spi_ready[1] = mready[1] & ~hold[1];

   // spi_tx model: ready drops for 70 cycles after it samples spi_req; it ignores wb_rst.
   always @(posedge clk) begin
      if (model_rst) begin
         viol   <= 1'b0;
         dbl    <= 1'b0;
         rdtbad <= 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         if (model_rst) begin
            mready[i] <= 1'b1;
            mcnt[i]   <= '0;
            reqs[i]   <= 0;
         end else begin
            if (spi_req[i]) begin
               mready[i] <= 1'b0;
               mcnt[i]   <= 7'd69;
               reqs[i]   <= reqs[i] + 1;
            end else if (!mready[i]) begin
               if (mcnt[i] == 7'd0) mready[i] <= 1'b1;
               else                 mcnt[i]   <= mcnt[i] - 7'd1;
            end
            if (spi_req[i] && !spi_ready[i]) viol <= 1'b1;
            if (m0_ack[i] && m1_ack[i]) dbl <= 1'b1;
            if ((!m0_ack[i] && m0_rdt[i] != 32'h0) || (!m1_ack[i] && m1_rdt[i] != 32'h0))
               rdtbad <= 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns the first ack on instance d: who = 0/1 (2 if both), n = cycles waited, -1 on timeout.
   task automatic wait_ack(input int d, output int who, output int n, output logic [31:0] rd);
      bit seen;
      who  = -1;
      n    = -1;
      rd   = 32'h0;
      seen = 1'b0;
      for (int k = 1; k <= 400 && !seen; k++) begin
         step();
         if (m0_ack[d] || m1_ack[d]) begin
            seen = 1'b1;
            who  = (m0_ack[d] && m1_ack[d]) ? 2 : (m1_ack[d] ? 1 : 0);
            n    = k;
            rd   = m1_ack[d] ? m1_rdt[d] : m0_rdt[d];
         end
      end
   endtask

   vec_t        vec[4];
   int          who, n, r0;
   logic [31:0] rd;

   initial begin
      vec[0] = '{1'b0, 32'h0000_0010, 32'h1122_3344, 24'h100010, 32'h4433_2211};
      vec[1] = '{1'b1, 32'h0000_2000, 32'hdead_beef, 24'h102000, 32'hefbe_adde};
      vec[2] = '{1'b0, 32'hff0f_ffff, 32'ha5a5_5a5a, 24'h1fffff, 32'h5a5a_a5a5};
      vec[3] = '{1'b1, 32'h0010_0004, 32'h0102_0304, 24'h100004, 32'h0403_0201};

      for (int i = 0; i < 2; i++) begin
         m0_adr[i] = '0; m1_adr[i] = '0; m0_cyc[i] = 1'b0; m1_cyc[i] = 1'b0;
         spi_rdata[i] = 32'h1122_3344; hold[i] = 1'b0;
      end

      // reset state
      repeat (3) step();
      check("rst_m0_ack", m0_ack[0], 1'b0);
      check("rst_m1_ack", m1_ack[0], 1'b0);
      check("rst_spi_req", spi_req[0], 1'b0);
      check("rst_spi_addr", spi_addr[0], 24'h0);
      check("rst_m0_rdt", m0_rdt[0], 32'h0);
      check("rst_spi_code", spi_code[0], 8'h03);
      check("rst_spi_tx_addr", spi_tx_addr[0], 1'b1);
      check("rst_spi_no_read", spi_no_read[0], 1'b0);
      model_rst = 1'b0;
      rst = 1'b0;
      step();

      // single-master reads
      for (int v = 0; v < 4; v++) begin
         r0 = reqs[0];
         spi_rdata[0] = vec[v].word;
         if (vec[v].m) begin m1_adr[0] = vec[v].adr; m1_cyc[0] = 1'b1; end
         else          begin m0_adr[0] = vec[v].adr; m0_cyc[0] = 1'b1; end
         wait_ack(0, who, n, rd);
         m0_cyc[0] = 1'b0;
         m1_cyc[0] = 1'b0;
         check("vec_who", who, vec[v].m);
         check("vec_latency", n, 73);
         check("vec_rdt", rd, vec[v].exp_rdt);
         check("vec_spi_addr", spi_addr[0], vec[v].exp_addr);
         check("vec_req_count", reqs[0] - r0, 1);
         step();
      end

      // round-robin with both masters requesting continuously
      spi_rdata[0] = 32'hcafe_f00d;
      m0_adr[0] = 32'h40; m1_adr[0] = 32'h80;
      m0_cyc[0] = 1'b1; m1_cyc[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_ack(0, who, n, rd);
         check("rr_who", who, k % 2);
         check("rr_latency", n, (k == 0) ? 73 : 74);
      end
      check("rr_rdt", rd, 32'h0df0_feca);
      m0_cyc[0] = 1'b0; m1_cyc[0] = 1'b0;
      step();

      // fixed priority: m1 wins every contention
      spi_rdata[1] = 32'h0a0b_0c0d;
      m0_adr[1] = 32'h100; m1_adr[1] = 32'h200;
      m0_cyc[1] = 1'b1; m1_cyc[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_ack(1, who, n, rd);
         check("prio_who", who, 1);
         check("prio_latency", n, (k == 0) ? 73 : 74);
      end
      m1_cyc[1] = 1'b0;
      wait_ack(1, who, n, rd);
      check("prio_m0_who", who, 0);
      check("prio_m0_rdt", rd, 32'h0d0c_0b0a);
      m0_cyc[1] = 1'b0;
      step();

      // m1 abandons its cycle during BUSY; pending m0 follows
      r0 = reqs[0];
      m0_adr[0] = 32'h400; m1_adr[0] = 32'h800;
      m1_cyc[0] = 1'b1;
      repeat (2) step();
      m0_cyc[0] = 1'b1;
      repeat (10) step();
      m1_cyc[0] = 1'b0;
      wait_ack(0, who, n, rd);
      m0_cyc[0] = 1'b0;
      check("abort_who", who, 0);
      check("abort_latency", n, 135);
      check("abort_rdt", rd, 32'h0df0_feca);
      check("abort_spi_addr", spi_addr[0], 24'h100400);
      check("abort_req_count", reqs[0] - r0, 2);
      step();

      // engine not ready after reset: nothing issued until ready rises
      rst = 1'b1;
      hold[0] = 1'b1;
      step();
      rst = 1'b0;
      r0 = reqs[0];
      m0_adr[0] = 32'h20; m0_cyc[0] = 1'b1;
      repeat (20) step();
      check("hold_req_count", reqs[0] - r0, 0);
      check("hold_spi_req", spi_req[0], 1'b0);
      hold[0] = 1'b0;
      wait_ack(0, who, n, rd);
      m0_cyc[0] = 1'b0;
      check("hold_latency", n, 73);
      check("hold_spi_addr", spi_addr[0], 24'h100020);
      step();

      // reset while BUSY, then recover behind the still-busy engine
      r0 = reqs[0];
      m0_adr[0] = 32'h30; m0_cyc[0] = 1'b1;
      repeat (20) step();
      rst = 1'b1;
      #1;
      check("rstbusy_m0_ack", m0_ack[0], 1'b0);
      check("rstbusy_spi_req", spi_req[0], 1'b0);
      check("rstbusy_spi_addr", spi_addr[0], 24'h0);
      repeat (2) step();
      rst = 1'b0;
      wait_ack(0, who, n, rd);
      m0_cyc[0] = 1'b0;
      check("rstbusy_latency", n, 123);
      check("rstbusy_rdt", rd, 32'h0df0_feca);
      check("rstbusy_req_count", reqs[0] - r0, 2);
      step();

      check("no_req_while_busy", viol, 1'b0);
      check("no_double_ack", dbl, 1'b0);
      check("rdt_zero_without_ack", rdtbad, 1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
